// File: rtl/ft_recovery_pkg.sv
// Shared types and constants for the lockstep fault-recovery controller.
package ft_recovery_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StCopy,
        StSettle,
        StResume,
        StFatal
    } rec_state_t;

    localparam int unsigned GPR_ADDR_W  = 5;
    localparam int unsigned RECOV_CNT_W = 8;

endpackage

// File: rtl/ft_sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear wins over increment.
module ft_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: halts both cores, restores x1..x31 from the shared GPR, resumes.
// Optional halt_ack timeout is enabled by defining FT_RECOVERY_TIMEOUT_EN.
module ft_recovery_ctrl
    import ft_recovery_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned SETTLE_CYCLES = 2
`ifdef FT_RECOVERY_TIMEOUT_EN
    ,
    parameter int unsigned HALT_TIMEOUT  = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mismatch_i,
    input  logic                   commit_i,
    input  logic                   halt_ack_i,
    output logic                   halt_o,
    output logic [GPR_ADDR_W-1:0]  sgpr_raddr_o,
    input  logic [DATA_WIDTH-1:0]  sgpr_rdata_i,
    output logic                   restore_we_o,
    output logic [GPR_ADDR_W-1:0]  restore_addr_o,
    output logic [DATA_WIDTH-1:0]  restore_data_o,
    output logic                   resume_o,
    output logic                   fatal_o,
    output logic [RECOV_CNT_W-1:0] recovery_cnt_o
);

    localparam int unsigned RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    rec_state_t           state;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic                 retry_at_max;
    logic                 start_recovery;
    logic                 clear_retry;

`ifdef FT_RECOVERY_TIMEOUT_EN
    localparam int unsigned HALT_CNT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT);
    logic [HALT_CNT_W-1:0] halt_cnt;
`endif

    assign retry_at_max   = (retry_cnt == RETRY_W'(MAX_RETRY));
    assign start_recovery = (state == StIdle) && mismatch_i && !retry_at_max;
    // A mismatch in the same cycle as a commit takes precedence.
    assign clear_retry    = (state == StIdle) && commit_i && !mismatch_i;

    ft_sat_counter #(
        .WIDTH (RETRY_W)
    ) u_retry_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (start_recovery),
        .clr   (clear_retry),
        .count (retry_cnt)
    );

    ft_sat_counter #(
        .WIDTH (RECOV_CNT_W)
    ) u_recovery_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (start_recovery),
        .clr   (1'b0),
        .count (recovery_cnt_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            halt_o         <= 1'b0;
            sgpr_raddr_o   <= '0;
            restore_we_o   <= 1'b0;
            restore_addr_o <= '0;
            restore_data_o <= '0;
            resume_o       <= 1'b0;
            fatal_o        <= 1'b0;
            settle_cnt     <= '0;
`ifdef FT_RECOVERY_TIMEOUT_EN
            halt_cnt       <= '0;
`endif
        end else begin
            restore_we_o   <= 1'b0;
            restore_addr_o <= '0;
            restore_data_o <= '0;
            resume_o       <= 1'b0;
            unique case (state)
                StIdle: begin
`ifdef FT_RECOVERY_TIMEOUT_EN
                    halt_cnt <= '0;
`endif
                    if (mismatch_i) begin
                        halt_o <= 1'b1;
                        if (retry_at_max) begin
                            state   <= StFatal;
                            fatal_o <= 1'b1;
                        end else begin
                            state <= StHalt;
                        end
                    end
                end
                StHalt: begin
                    if (halt_ack_i) begin
                        state        <= StCopy;
                        sgpr_raddr_o <= GPR_ADDR_W'(1);
                    end
`ifdef FT_RECOVERY_TIMEOUT_EN
                    else if (halt_cnt == HALT_CNT_W'(HALT_TIMEOUT - 1)) begin
                        state   <= StFatal;
                        fatal_o <= 1'b1;
                    end else begin
                        halt_cnt <= halt_cnt + HALT_CNT_W'(1);
                    end
`endif
                end
                StCopy: begin
                    // Read data is combinational from the address, so capture it directly.
                    restore_we_o   <= 1'b1;
                    restore_addr_o <= sgpr_raddr_o;
                    restore_data_o <= sgpr_rdata_i;
                    if (sgpr_raddr_o == GPR_ADDR_W'(NUM_REGS - 1)) begin
                        state        <= StSettle;
                        sgpr_raddr_o <= '0;
                        settle_cnt   <= '0;
                    end else begin
                        sgpr_raddr_o <= sgpr_raddr_o + GPR_ADDR_W'(1);
                    end
                end
                StSettle: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES)) begin
                        state    <= StResume;
                        resume_o <= 1'b1;
                        halt_o   <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                StResume: begin
                    state <= StIdle;
                end
                StFatal: begin
                    state <= StFatal;
                end
                default: begin
                    state  <= StIdle;
                    halt_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed/randomized bench for ft_recovery_ctrl against a transaction-level recovery model.
module tb_ft_recovery_ctrl;

    localparam int NREGS     = 32;
    localparam int MAXRETRY  = 3;
    localparam int SETTLE    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mismatch;
    logic        commit;
    logic        halt_ack;
    logic        halt;
    logic [4:0]  sgpr_raddr;
    logic [31:0] sgpr_rdata;
    logic        restore_we;
    logic [4:0]  restore_addr;
    logic [31:0] restore_data;
    logic        resume;
    logic        fatal;
    logic [7:0]  recovery_cnt;

    logic [31:0] sgpr [NREGS];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: retries since last good commit, recoveries started.
    int model_retry = 0;
    int model_recov = 0;

    logic [4:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int first_we;
    int last_we;
    int resume_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sgpr_rdata = sgpr[sgpr_raddr];

    ft_recovery_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mismatch_i     (mismatch),
        .commit_i       (commit),
        .halt_ack_i     (halt_ack),
        .halt_o         (halt),
        .sgpr_raddr_o   (sgpr_raddr),
        .sgpr_rdata_i   (sgpr_rdata),
        .restore_we_o   (restore_we),
        .restore_addr_o (restore_addr),
        .restore_data_o (restore_data),
        .resume_o       (resume),
        .fatal_o        (fatal),
        .recovery_cnt_o (recovery_cnt)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (restore_we) begin
                wa_q.push_back(restore_addr);
                wd_q.push_back(restore_data);
                if (wa_q.size() == 1) first_we = cyc;
                last_we = cyc;
            end
            if (resume) resume_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        first_we   = -1;
        last_we    = -1;
        resume_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        mismatch = 1'b0;
        commit   = 1'b0;
        halt_ack = 1'b0;
        step();
        step();
        rst_n       = 1'b1;
        model_retry = 0;
        model_recov = 0;
        step();
    endtask

    task automatic fill_sgpr(input bit pattern);
        for (int i = 0; i < NREGS; i++)
            sgpr[i] = pattern ? 32'h100 + 32'(i) : $urandom;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit      = 1'b0;
        model_retry = 0;
    endtask

    // One mismatch event: the model decides between a full recovery and escalation to fatal.
    task automatic mismatch_event(input int d, input bit with_commit);
        int m;
        int n;
        int bad;
        bit exp_fatal;
        clear_log();
        exp_fatal = (model_retry == MAXRETRY);
        if (!exp_fatal) begin
            model_retry++;
            model_recov = (model_recov < 255) ? model_recov + 1 : 255;
        end
        m        = cyc;
        mismatch = 1'b1;
        commit   = with_commit;
        step();
        mismatch = 1'b0;
        commit   = 1'b0;
        check("halt_rise", halt, 1);
        check("fatal_on_event", fatal, exp_fatal);
        if (exp_fatal) begin
            for (int k = 0; k < 20; k++) begin
                mismatch = 1'($urandom);
                commit   = 1'($urandom);
                halt_ack = 1'($urandom);
                step();
            end
            mismatch = 1'b0;
            commit   = 1'b0;
            halt_ack = 1'b0;
            check("fatal_sticky", fatal, 1);
            check("fatal_halt_held", halt, 1);
            check("fatal_no_writes", wa_q.size(), 0);
            check("fatal_no_resume", resume_cyc, -1);
            check("fatal_raddr", sgpr_raddr, 0);
            return;
        end
        repeat (d) step();
        halt_ack = 1'b1;
        n = 0;
        while (!resume && n < 300) begin
            step();
            n++;
        end
        halt_ack = 1'b0;
        check("resume_seen", resume, 1);
        check("halt_low_at_resume", halt, 0);
        check("write_count", wa_q.size(), NREGS - 1);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 5'(i + 1) || wd_q[i] !== sgpr[i + 1]) bad++;
        check("write_content", bad, 0);
        check("first_write_latency", first_we - (m + 1), 2 + d);
        check("writes_contiguous", last_we - first_we, NREGS - 2);
        check("settle_gap", resume_cyc - last_we, SETTLE + 1);
        check("recovery_cnt", recovery_cnt, model_recov);
        step();
        check("resume_one_cycle", resume, 0);
        check("halt_idle", halt, 0);
    endtask

    initial begin
        int n;
        clear_log();
        fill_sgpr(1'b0);

        // Reset held with mismatch asserted.
        rst_n    = 1'b0;
        mismatch = 1'b1;
        commit   = 1'b0;
        halt_ack = 1'b0;
        repeat (3) step();
        check("rst_halt", halt, 0);
        check("rst_fatal", fatal, 0);
        check("rst_resume", resume, 0);
        check("rst_we", restore_we, 0);
        check("rst_raddr", sgpr_raddr, 0);
        check("rst_rcnt", recovery_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("release_halt_low", halt, 0);
        step();
        check("release_halt_rise", halt, 1);
        check("release_rcnt", recovery_cnt, 1);
        do_reset();

        // Single recovery with the documented GPR pattern and 3-cycle ack delay.
        fill_sgpr(1'b1);
        mismatch_event(3, 1'b0);

        // Escalation: four mismatches with no commit.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fill_sgpr(1'b0);
            mismatch_event(int'($urandom_range(0, 5)), 1'b0);
        end

        // Commit clears the retry count; mismatch wins over a simultaneous commit.
        do_reset();
        fill_sgpr(1'b0);
        mismatch_event(int'($urandom_range(0, 5)), 1'b0);
        do_commit();
        for (int k = 0; k < 3; k++) begin
            fill_sgpr(1'b0);
            mismatch_event(int'($urandom_range(0, 5)), 1'b0);
        end
        do_commit();
        fill_sgpr(1'b0);
        mismatch_event(int'($urandom_range(0, 5)), 1'b1);
        for (int k = 0; k < 2; k++) begin
            fill_sgpr(1'b0);
            mismatch_event(int'($urandom_range(0, 5)), 1'b0);
        end
        mismatch_event(0, 1'b1);

        // Reset in the middle of the copy.
        do_reset();
        clear_log();
        fill_sgpr(1'b0);
        mismatch = 1'b1;
        step();
        mismatch = 1'b0;
        halt_ack = 1'b1;
        n = 0;
        while (sgpr_raddr !== 5'd10 && n < 100) begin
            step();
            n++;
        end
        check("reached_idx10", sgpr_raddr, 10);
        check("writes_before_reset", wa_q.size(), 9);
        rst_n = 1'b0;
        #1;
        check("midcopy_we_drop", restore_we, 0);
        check("midcopy_halt_drop", halt, 0);
        step();
        rst_n    = 1'b1;
        halt_ack = 1'b0;
        repeat (3) step();
        check("post_reset_idle_halt", halt, 0);
        check("post_reset_rcnt", recovery_cnt, 0);
        check("no_writes_after_reset", wa_q.size(), 9);
        model_retry = 0;
        model_recov = 0;

        // halt_ack never arrives.
        do_reset();
        clear_log();
        mismatch = 1'b1;
        step();
        mismatch = 1'b0;
`ifdef FT_RECOVERY_TIMEOUT_EN
        repeat (63) step();
        check("timeout_not_yet", fatal, 0);
        step();
        check("timeout_fatal", fatal, 1);
        check("timeout_halt", halt, 1);
`else
        repeat (1000) step();
        check("no_timeout_halt", halt, 1);
        check("no_timeout_fatal", fatal, 0);
        check("no_timeout_writes", wa_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
